// File: rtl/xm_mem_sequencer.sv
// Multi-cycle fetch/load/store sequencer: effective address, byte lanes, bounded busy wait, read formatting.
// Latency: ISSUE one cycle after accept, done_o three or more cycles after accept; start_i is only taken while idle.
`timescale 1ns/1ps
module xm_mem_sequencer #(
  parameter int WORD    = 16,
  parameter int TIMEOUT = 15,
  localparam int LANES  = WORD / 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic             byte_i,
  input  logic             sext_i,
  input  logic             pre_i,
  input  logic             wb_i,
  input  logic [WORD-1:0]  base_i,
  input  logic [WORD-1:0]  offs_i,
  input  logic [WORD-1:0]  wdata_i,
  input  logic             mem_busy_i,
  input  logic [WORD-1:0]  mem_rdata_i,
  output logic             mem_en_o,
  output logic             mem_rw_o,
  output logic [WORD-1:0]  mem_adr_o,
  output logic [LANES-1:0] mem_be_o,
  output logic [WORD-1:0]  mem_wdata_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WORD-1:0]  rdata_o,
  output logic             base_wb_o,
  output logic [WORD-1:0]  base_val_o,
  output logic             fault_o,
  output logic [1:0]       fault_code_o
);

  localparam int LB = $clog2(LANES);
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WB    = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  localparam logic [1:0] OP_STORE = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  localparam logic [1:0] F_MISALIGN = 2'd1;
  localparam logic [1:0] F_TIMEOUT  = 2'd2;
  localparam logic [1:0] F_ILLEGAL  = 2'd3;

  logic [2:0]      state_q;
  logic [CW-1:0]   wait_cnt_q;
  logic [1:0]      op_q;
  logic            byte_q;
  logic            sext_q;
  logic            wb_q;
  logic [LB-1:0]   lane_q;
  logic [WORD-1:0] sum_q;

  logic [WORD-1:0]  sum_d;
  logic [WORD-1:0]  ea_d;
  logic [LB-1:0]    lane_d;
  logic [LANES-1:0] be_d;
  logic [WORD-1:0]  wdata_d;
  logic [7:0]       rd_byte;
  logic [WORD-1:0]  rdata_d;

  always_comb begin
    sum_d   = base_i + offs_i;
    ea_d    = pre_i ? sum_d : base_i;
    lane_d  = ea_d[LB-1:0];
    be_d    = byte_i ? (LANES'(1) << lane_d) : '1;
    wdata_d = byte_i ? {LANES{wdata_i[7:0]}} : wdata_i;
  end

  // Read data is formatted on the way into rdata_o so it is ready in the WB cycle.
  always_comb begin
    rd_byte = 8'(mem_rdata_i >> {lane_q, 3'b000});
    if (op_q == OP_STORE) begin
      rdata_d = '0;
    end else if (byte_q) begin
      rdata_d = {{(WORD-8){sext_q & rd_byte[7]}}, rd_byte};
    end else begin
      rdata_d = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      wait_cnt_q   <= '0;
      op_q         <= '0;
      byte_q       <= 1'b0;
      sext_q       <= 1'b0;
      wb_q         <= 1'b0;
      lane_q       <= '0;
      sum_q        <= '0;
      mem_en_o     <= 1'b0;
      mem_rw_o     <= 1'b0;
      mem_adr_o    <= '0;
      mem_be_o     <= '0;
      mem_wdata_o  <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      rdata_o      <= '0;
      base_wb_o    <= 1'b0;
      base_val_o   <= '0;
      fault_o      <= 1'b0;
      fault_code_o <= '0;
    end else begin
      mem_en_o  <= 1'b0;
      done_o    <= 1'b0;
      base_wb_o <= 1'b0;
      fault_o   <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            op_q         <= op_i;
            byte_q       <= byte_i;
            sext_q       <= sext_i;
            wb_q         <= wb_i;
            lane_q       <= lane_d;
            sum_q        <= sum_d;
            busy_o       <= 1'b1;
            fault_code_o <= '0;
            if (op_i == OP_ILL) begin
              state_q      <= S_FAULT;
              fault_o      <= 1'b1;
              fault_code_o <= F_ILLEGAL;
            end else if (!byte_i && (lane_d != '0)) begin
              state_q      <= S_FAULT;
              fault_o      <= 1'b1;
              fault_code_o <= F_MISALIGN;
            end else begin
              // Bus outputs are loaded here so they are valid throughout ISSUE.
              state_q     <= S_ISSUE;
              mem_en_o    <= 1'b1;
              mem_rw_o    <= (op_i == OP_STORE);
              mem_adr_o   <= ea_d;
              mem_be_o    <= be_d;
              mem_wdata_o <= (op_i == OP_STORE) ? wdata_d : '0;
            end
          end
        end

        S_ISSUE: begin
          wait_cnt_q <= '0;
          state_q    <= S_WAIT;
        end

        S_WAIT: begin
          // Completion is checked first so it wins over the timeout limit.
          if (!mem_busy_i) begin
            state_q    <= S_WB;
            done_o     <= 1'b1;
            rdata_o    <= rdata_d;
            base_wb_o  <= wb_q;
            base_val_o <= sum_q;
          end else if (wait_cnt_q == CW'(TIMEOUT - 1)) begin
            state_q      <= S_FAULT;
            fault_o      <= 1'b1;
            fault_code_o <= F_TIMEOUT;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
        end

        S_WB: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end

        S_FAULT: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xm_mem_sequencer.sv
// Directed bench for xm_mem_sequencer (WORD=16, TIMEOUT=15) with a queue scoreboard.
`timescale 1ns/1ps
module tb_xm_mem_sequencer;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  op_i = '0;
  logic        byte_i = 1'b0;
  logic        sext_i = 1'b0;
  logic        pre_i = 1'b0;
  logic        wb_i = 1'b0;
  logic [15:0] base_i = '0;
  logic [15:0] offs_i = '0;
  logic [15:0] wdata_i = '0;
  logic        mem_busy_i = 1'b1;
  logic [15:0] mem_rdata_i = '0;
  logic        mem_en_o, mem_rw_o, busy_o, done_o, base_wb_o, fault_o;
  logic [15:0] mem_adr_o, mem_wdata_o, rdata_o, base_val_o;
  logic [1:0]  mem_be_o, fault_code_o;

  xm_mem_sequencer #(.WORD(16), .TIMEOUT(15)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .op_i(op_i), .byte_i(byte_i),
    .sext_i(sext_i), .pre_i(pre_i), .wb_i(wb_i), .base_i(base_i), .offs_i(offs_i),
    .wdata_i(wdata_i), .mem_busy_i(mem_busy_i), .mem_rdata_i(mem_rdata_i),
    .mem_en_o(mem_en_o), .mem_rw_o(mem_rw_o), .mem_adr_o(mem_adr_o), .mem_be_o(mem_be_o),
    .mem_wdata_o(mem_wdata_o), .busy_o(busy_o), .done_o(done_o), .rdata_o(rdata_o),
    .base_wb_o(base_wb_o), .base_val_o(base_val_o), .fault_o(fault_o),
    .fault_code_o(fault_code_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [15:0] adr;
    logic [1:0]  be;
    logic        rw;
    logic [15:0] wd;
  } bus_t;

  typedef struct {
    int          cyc;
    logic        flt;
    logic [1:0]  code;
    logic [15:0] rdata;
    logic        wb;
    logic [15:0] bval;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];
  bus_t eb;
  res_t er;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every bus strobe and every done/fault pulse must match the head of its queue.
  always @(negedge clk) begin
    if (mem_en_o) begin
      if (bus_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_issue: mem_en_o=1 at cycle %0d, none expected", cyc);
      end else begin
        eb = bus_q.pop_front();
        chk("issue_cycle", cyc, eb.cyc);
        chk("issue_adr", mem_adr_o, eb.adr);
        chk("issue_be", mem_be_o, eb.be);
        chk("issue_rw", mem_rw_o, eb.rw);
        if (eb.rw) chk("issue_wdata", mem_wdata_o, eb.wd);
        chk("issue_busy", busy_o, 1'b1);
      end
    end
    if (done_o || fault_o) begin
      if (res_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_resp: done=%0b fault=%0b at cycle %0d, none expected",
                 done_o, fault_o, cyc);
      end else begin
        er = res_q.pop_front();
        chk("resp_cycle", cyc, er.cyc);
        chk("resp_kind", {done_o, fault_o}, er.flt ? 2'b01 : 2'b10);
        chk("resp_busy", busy_o, 1'b1);
        if (er.flt) begin
          chk("fault_code", fault_code_o, er.code);
          chk("fault_no_wb", base_wb_o, 1'b0);
        end else begin
          chk("rdata", rdata_o, er.rdata);
          chk("base_wb", base_wb_o, er.wb);
          chk("base_val", base_val_o, er.bval);
          chk("fault_code_clear", fault_code_o, 2'd0);
        end
      end
    end
  end

  task automatic req(input logic [1:0] op, input logic byt, input logic sext, input logic pre,
                     input logic wb, input logic [15:0] base, input logic [15:0] offs,
                     input logic [15:0] wdata, input logic [15:0] rd, input int nbusy,
                     input logic issue, input logic [15:0] e_adr, input logic [1:0] e_be,
                     input logic e_rw, input logic [15:0] e_wd, input logic flt,
                     input logic [1:0] code, input logic [15:0] e_rdata, input logic e_wb,
                     input logic [15:0] e_bval, input int lat);
    bus_t b;
    res_t r;
    int   s;
    op_i = op; byte_i = byt; sext_i = sext; pre_i = pre; wb_i = wb;
    base_i = base; offs_i = offs; wdata_i = wdata;
    start_i = 1'b1;
    s = cyc;
    if (issue) begin
      b.cyc = s + 1; b.adr = e_adr; b.be = e_be; b.rw = e_rw; b.wd = e_wd;
      bus_q.push_back(b);
    end
    r.cyc = s + lat; r.flt = flt; r.code = code; r.rdata = e_rdata; r.wb = e_wb; r.bval = e_bval;
    res_q.push_back(r);
    @(posedge clk); #1;
    start_i = 1'b0;
    if (issue) begin
      @(posedge clk); #1;
      for (int i = 0; i < nbusy; i++) begin
        mem_busy_i = 1'b1;
        @(posedge clk); #1;
      end
      mem_busy_i  = 1'b0;
      mem_rdata_i = rd;
      @(posedge clk); #1;
      mem_busy_i  = 1'b1;
      mem_rdata_i = '0;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    bus_t b;
    res_t r;
    int   s;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {mem_en_o, mem_rw_o, mem_adr_o, mem_be_o, mem_wdata_o, busy_o, done_o,
                        rdata_o, base_wb_o, base_val_o, fault_o, fault_code_o}, 80'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    // op byt sext pre wb  base offs wdata  rd nbusy  issue adr be rw wd  flt code  rdata wb bval  lat
    req(2'b01, 0, 0, 1, 1, 16'h0100, 16'h0004, 16'h0000, 16'hBEEF, 0,
        1, 16'h0104, 2'b11, 0, 16'h0000, 0, 2'd0, 16'hBEEF, 1, 16'h0104, 3);
    req(2'b01, 1, 1, 0, 0, 16'h0201, 16'hFFFF, 16'h0000, 16'h80AA, 0,
        1, 16'h0201, 2'b10, 0, 16'h0000, 0, 2'd0, 16'hFF80, 0, 16'h0200, 3);
    req(2'b10, 1, 0, 1, 1, 16'h000C, 16'h0004, 16'h1234, 16'hFFFF, 3,
        1, 16'h0010, 2'b01, 1, 16'h3434, 0, 2'd0, 16'h0000, 1, 16'h0010, 6);
    req(2'b01, 1, 1, 0, 0, 16'h0031, 16'h0001, 16'h0000, 16'h5A80, 1,
        1, 16'h0031, 2'b10, 0, 16'h0000, 0, 2'd0, 16'h005A, 0, 16'h0032, 4);
    req(2'b01, 1, 0, 1, 1, 16'h0030, 16'h0000, 16'h0000, 16'h7F9C, 0,
        1, 16'h0030, 2'b01, 0, 16'h0000, 0, 2'd0, 16'h009C, 1, 16'h0030, 3);
    req(2'b10, 0, 0, 0, 0, 16'h0200, 16'h0010, 16'hA5C3, 16'h1111, 0,
        1, 16'h0200, 2'b11, 1, 16'hA5C3, 0, 2'd0, 16'h0000, 0, 16'h0210, 3);
    req(2'b00, 0, 0, 1, 1, 16'hFFFE, 16'h0004, 16'h0000, 16'hCAFE, 2,
        1, 16'h0002, 2'b11, 0, 16'h0000, 0, 2'd0, 16'hCAFE, 1, 16'h0002, 5);

    // Faults detected at accept time: no bus strobe expected.
    req(2'b01, 0, 0, 0, 1, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 0,
        0, 16'h0000, 2'b00, 0, 16'h0000, 1, 2'd1, 16'h0000, 0, 16'h0000, 1);
    req(2'b10, 0, 0, 1, 1, 16'h0100, 16'h0001, 16'hFFFF, 16'h0000, 0,
        0, 16'h0000, 2'b00, 0, 16'h0000, 1, 2'd1, 16'h0000, 0, 16'h0000, 1);
    req(2'b11, 1, 0, 0, 1, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 0,
        0, 16'h0000, 2'b00, 0, 16'h0000, 1, 2'd3, 16'h0000, 0, 16'h0000, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("fault_code_hold", fault_code_o, 2'd3);
    chk("rdata_hold", rdata_o, 16'hCAFE);
    chk("base_val_hold", base_val_o, 16'h0002);
    chk("idle_busy", busy_o, 1'b0);

    // Timeout after exactly 15 busy WAIT cycles, then completion on the 15th WAIT cycle.
    req(2'b01, 0, 0, 0, 0, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 15,
        1, 16'h0020, 2'b11, 0, 16'h0000, 1, 2'd2, 16'h0000, 0, 16'h0000, 17);
    req(2'b01, 0, 0, 0, 0, 16'h0040, 16'h0002, 16'h0000, 16'h1357, 14,
        1, 16'h0040, 2'b11, 0, 16'h0000, 0, 2'd0, 16'h1357, 0, 16'h0042, 17);

    // A start pulse during WAIT carrying an illegal op must be ignored.
    op_i = 2'b01; byte_i = 1'b0; sext_i = 1'b0; pre_i = 1'b0; wb_i = 1'b0;
    base_i = 16'h0050; offs_i = 16'h0000;
    start_i = 1'b1;
    s = cyc;
    b.cyc = s + 1; b.adr = 16'h0050; b.be = 2'b11; b.rw = 1'b0; b.wd = 16'h0000;
    bus_q.push_back(b);
    r.cyc = s + 4; r.flt = 1'b0; r.code = 2'd0; r.rdata = 16'h2468; r.wb = 1'b0; r.bval = 16'h0050;
    res_q.push_back(r);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b11; mem_busy_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; mem_busy_i = 1'b0; mem_rdata_i = 16'h2468;
    @(posedge clk); #1;
    mem_busy_i = 1'b1; mem_rdata_i = '0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in WAIT aborts with all outputs zero and no pulses.
    op_i = 2'b01; base_i = 16'h0060;
    start_i = 1'b1;
    s = cyc;
    b.cyc = s + 1; b.adr = 16'h0060; b.be = 2'b11; b.rw = 1'b0; b.wd = 16'h0000;
    bus_q.push_back(b);
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    mem_busy_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    chk("reset_abort", {mem_en_o, mem_rw_o, mem_adr_o, mem_be_o, mem_wdata_o, busy_o, done_o,
                        rdata_o, base_wb_o, base_val_o, fault_o, fault_code_o}, 80'd0);
    rst_i = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_idle_busy", busy_o, 1'b0);

    req(2'b01, 0, 0, 1, 1, 16'h0070, 16'h0002, 16'h0000, 16'h0F0F, 1,
        1, 16'h0072, 2'b11, 0, 16'h0000, 0, 2'd0, 16'h0F0F, 1, 16'h0072, 4);

    for (int i = 0; i < 20 && (bus_q.size() + res_q.size()) != 0; i++) @(posedge clk);
    #1;
    chk("drain", bus_q.size() + res_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/xm_mem_sequencer.md
Name: xm_mem_sequencer

Overview:
- Parametrised multi-cycle memory-access sequencer for the XM core. Takes one fetch/load/store request from the main controller and computes the effective address (pre/post offset).
- Drives the memory bus with byte enables and waits on the busy handshake with a bounded timeout.
- Returns lane-aligned read data, an optional base-register writeback value, or a fault code.
- Generalises the controller's ACC/REL load/store and MEM_CONFIRM/MEM_WRITEBACK states to any multiple-of-8 word width, with misalignment, timeout and illegal-op detection.

Parameters:
- WORD, 16, data/address width in bits; multiple of 8, at least 16.
- TIMEOUT, 15, max WAIT cycles with mem_busy_i high before timeout fault; at least 1.
- LANES, WORD/8, derived byte-lane count; LB = clog2(LANES) lane-select bits.

Ports:
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  synchronous reset, active-high
- start_i  in  1  request strobe, accepted only in IDLE
- op_i  in  2  00 fetch, 01 load, 10 store, 11 illegal
- byte_i  in  1  1 = byte access, 0 = word access
- sext_i  in  1  sign-extend byte loads
- pre_i  in  1  1 = address is base+offs, 0 = address is base
- wb_i  in  1  request base writeback of base+offs
- base_i  in  WORD  base address
- offs_i  in  WORD  two's-complement offset
- wdata_i  in  WORD  store data; a byte store uses bits [7:0]
- mem_busy_i  in  1  memory busy; low in WAIT means the access is complete
- mem_rdata_i  in  WORD  read data, valid in the cycle mem_busy_i is low in WAIT
- mem_en_o  out  1  access strobe
- mem_rw_o  out  1  1 = write
- mem_adr_o  out  WORD  effective address
- mem_be_o  out  LANES  byte enables
- mem_wdata_o  out  WORD  write data
- busy_o  out  1  sequencer not IDLE
- done_o  out  1  one-cycle completion pulse
- rdata_o  out  WORD  formatted read data
- base_wb_o  out  1  one-cycle base writeback strobe
- base_val_o  out  WORD  base+offs, modulo 2^WORD
- fault_o  out  1  one-cycle fault pulse
- fault_code_o  out  2  1 misaligned, 2 timeout, 3 illegal op; held until the next accepted start

Behaviour:
- All outputs are registered.
- Reset values: every output is 0, the wait counter is 0, state is IDLE. Reset mid-operation aborts in the next cycle with no done, fault or writeback pulse.
- States: IDLE, ISSUE, WAIT, WB, FAULT.
- IDLE:
  - start_i=1 latches all request inputs.
  - ea = pre_i ? base_i+offs_i : base_i; sum wraps modulo 2^WORD.
  - Goes to FAULT if op_i=11 (code 3) or if word access with ea[LB-1:0]!=0 (code 1); otherwise goes to ISSUE.
  - start_i outside IDLE is ignored.
- ISSUE (exactly 1 cycle):
  - mem_en_o=1, mem_adr_o=ea, mem_rw_o=(op=store).
  - Word access: mem_be_o all ones. Byte access: one-hot at lane ea[LB-1:0].
  - Byte store replicates wdata[7:0] across every lane of mem_wdata_o.
  - Counter cleared; next state WAIT.
- WAIT:
  - mem_en_o=0.
  - mem_busy_i=0: capture mem_rdata_i and go to WB.
  - mem_busy_i=1: counter increments. When counter==TIMEOUT-1 with busy still high, go to FAULT code 2.
  - Completion in the same cycle as the timeout limit: completion wins.
- WB (1 cycle):
  - done_o=1.
  - Word access: rdata_o = captured word.
  - Byte access: selected lane in rdata_o[7:0]; upper bits are zero, or copies of bit 7 when sext_i=1.
  - Stores: rdata_o=0.
  - base_wb_o = latched wb_i; base_val_o = base+offs.
  - Next state IDLE.
- FAULT (1 cycle): fault_o=1, no memory strobe, no base writeback; next state IDLE.
- busy_o=1 in every state except IDLE.
- Minimum latency: start accepted in cycle 0, ISSUE in cycle 1, WAIT in cycle 2, done_o in cycle 3.
- rdata_o and base_val_o hold their values until the next WB.

Test Plan:
- Word load, base=0x0100, offs=0x0004, pre=1, wb=1, busy low in the first WAIT cycle -> ISSUE drives adr 0x0104, be=11; mem_rdata=0xBEEF; done in cycle 3 with rdata=0xBEEF; base_wb=1 with base_val=0x0104.
- Sign-extended byte load, post mode, base=0x0201, offs=0xFFFF, sext=1, mem_rdata=0x80AA -> adr=0x0201, be=10, rdata=0xFF80, base_val=0x0200.
- Byte store wdata=0x1234 at ea 0x0010 with busy high for 3 WAIT cycles -> mem_wdata=0x3434, be=01, rw=1, done after 4 WAIT cycles, rdata=0.
- Word access at ea 0x0003 -> fault_o in cycle 1, fault_code=1, mem_en never asserted; op=11 -> fault_code=3.
- mem_busy_i held high -> fault_o after exactly TIMEOUT WAIT cycles, code 2. Busy dropped in WAIT cycle TIMEOUT -> done, no fault.
- rst_i asserted in WAIT -> next cycle IDLE, all outputs 0, no done/fault. A start_i pulse during WAIT is ignored.
